// File: rtl/eth_fcs_append.sv
// eth_fcs_append
//   Takes the builder's {valid, byte} frame stream and drives a byte-wide
//   GMII-style transmit interface. It prepends the preamble and SFD, zero-pads
//   short frames to MIN_DATA bytes, and appends the CRC-32 FCS. It then holds
//   the line idle for IFG_CYCLES cycles.
// Ports
//   eth_rxck    : clock, rising edge
//   rst_rx      : synchronous active-high reset
//   UDP_i       : [8] byte valid, [7:0] frame byte
//   txd_o       : transmit byte
//   txen_o      : transmit enable
//   busy_o      : high whenever the FSM is not idle
//   frame_cnt_o : frames fully sent (wraps)
//   drop_cnt_o  : input runs discarded (saturates)
module eth_fcs_append #(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_DATA   = 60
) (
    input  logic        eth_rxck,
    input  logic        rst_rx,
    input  logic [8:0]  UDP_i,
    output logic [7:0]  txd_o,
    output logic        txen_o,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o,
    output logic [7:0]  drop_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [11:0] MIN_W    = 12'(MIN_DATA);

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;       // PRE / FCS / IFG position
    logic [11:0]       dcnt, dcnt_n;     // data + pad bytes sent, saturating
    logic [31:0]       crc, crc_n;
    logic [7:0]        txd_n;
    logic              txen_n;
    logic [31:0]       crc_inv;
    // The 8 stages here plus the txd_o register make up the 9-cycle latency.
    logic [7:0][8:0]   dly;
    logic              in_frame;         // current input run belongs to the frame in flight
    logic              drop_run;         // current input run is being discarded
    logic              accept;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // A byte is taken only while its run continues the current frame. A new
    // run can start a frame only in IDLE, and only if it did not begin as a
    // dropped run.
    assign accept  = UDP_i[8] & (in_frame | ((state == S_IDLE) & ~drop_run));
    assign crc_inv = ~crc;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dcnt_n  = dcnt;
        crc_n   = crc;
        txd_n   = 8'h00;
        txen_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_PRE;
                    cnt_n   = 8'd0;
                    dcnt_n  = 12'd0;
                    crc_n   = 32'hFFFFFFFF;
                    txd_n   = 8'h55;
                    txen_n  = 1'b1;
                end
            end
            S_PRE: begin
                txen_n = 1'b1;
                if (cnt == 8'd7) begin
                    // The first data byte has reached the end of the delay line.
                    state_n = S_DATA;
                    txd_n   = dly[7][7:0];
                    crc_n   = crc_byte(crc, dly[7][7:0]);
                    dcnt_n  = 12'd1;
                end else begin
                    cnt_n = cnt + 8'd1;
                    txd_n = (cnt == 8'd6) ? 8'hD5 : 8'h55;
                end
            end
            S_DATA: begin
                txen_n = 1'b1;
                if (dly[7][8]) begin
                    txd_n  = dly[7][7:0];
                    crc_n  = crc_byte(crc, dly[7][7:0]);
                    dcnt_n = (dcnt == 12'hFFF) ? dcnt : dcnt + 12'd1;
                end else if (dcnt < MIN_W) begin
                    state_n = S_PAD;
                    crc_n   = crc_byte(crc, 8'h00);
                    dcnt_n  = dcnt + 12'd1;
                end else begin
                    state_n = S_FCS;
                    cnt_n   = 8'd0;
                    txd_n   = crc_inv[7:0];
                end
            end
            S_PAD: begin
                txen_n = 1'b1;
                if (dcnt == MIN_W) begin
                    state_n = S_FCS;
                    cnt_n   = 8'd0;
                    txd_n   = crc_inv[7:0];
                end else begin
                    crc_n  = crc_byte(crc, 8'h00);
                    dcnt_n = dcnt + 12'd1;
                end
            end
            S_FCS: begin
                // cnt is the index of the FCS byte now on the wire.
                if (cnt == 8'd3) begin
                    state_n = S_IFG;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n  = cnt + 8'd1;
                    txen_n = 1'b1;
                    txd_n  = 8'(crc_inv >> {cnt[1:0] + 2'd1, 3'b000});
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) state_n = S_IDLE;
                else                 cnt_n   = cnt + 8'd1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge eth_rxck) begin
        if (rst_rx) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dcnt        <= '0;
            crc         <= 32'hFFFFFFFF;
            dly         <= '0;
            in_frame    <= 1'b0;
            drop_run    <= 1'b0;
            txd_o       <= '0;
            txen_o      <= 1'b0;
            busy_o      <= 1'b0;
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dcnt     <= dcnt_n;
            crc      <= crc_n;
            dly      <= {dly[6:0], {accept, accept ? UDP_i[7:0] : 8'h00}};
            in_frame <= accept;
            drop_run <= UDP_i[8] & ~accept;
            txd_o    <= txd_n;
            txen_o   <= txen_n;
            busy_o   <= (state_n != S_IDLE);
            if (state == S_FCS && cnt == 8'd3)
                frame_cnt_o <= frame_cnt_o + 16'd1;
            if (UDP_i[8] & ~accept & ~drop_run & (drop_cnt_o != 8'hFF))
                drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end

endmodule
